// File: rtl/mc_pkg.sv
// mc_pkg: state encodings, MIPS opcode/funct constants and select encodings for the multi-cycle control
package mc_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRJ    = 3'd5
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_NOP  = 6'b000000;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] MR_ALU = 2'b00, MR_DM = 2'b01, MR_LUI = 2'b10, MR_PC4 = 2'b11;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010;
  localparam logic [1:0] NPC_PC4 = 2'b00, NPC_BR = 2'b01, NPC_JAL = 2'b10, NPC_RS = 2'b11;
  // One-hot instruction class; all-zero means the instruction is not recognised.
  typedef struct packed {
    logic addu, subu, ori, lw, sw, beq, lui, jal, jr, nop;
  } cls_t;
  // Full control word, packed in the order the outputs appear on the top.
  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] mem_to_r;
    logic [2:0] alu_op;
    logic       ext_op;
    logic [1:0] npc_sel;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct classification into a one-hot instruction class plus illegal flag
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output cls_t       o_cls,
  output logic       o_illegal
);
  logic w_r;
  assign w_r        = i_opcode == OP_R;
  assign o_cls.addu = w_r && i_funct == FN_ADDU;
  assign o_cls.subu = w_r && i_funct == FN_SUBU;
  assign o_cls.jr   = w_r && i_funct == FN_JR;
  assign o_cls.nop  = w_r && i_funct == FN_NOP;
  assign o_cls.ori  = i_opcode == OP_ORI;
  assign o_cls.lw   = i_opcode == OP_LW;
  assign o_cls.sw   = i_opcode == OP_SW;
  assign o_cls.beq  = i_opcode == OP_BEQ;
  assign o_cls.lui  = i_opcode == OP_LUI;
  assign o_cls.jal  = i_opcode == OP_JAL;
  assign o_illegal  = ~|o_cls;
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with retired-instruction counter; MC_MEM_WAIT_EN makes MEM wait on mem_rdy
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_rdy,
  output logic             pcWr,
  output logic             irWr,
  output logic             regWr,
  output logic             memWr,
  output logic [1:0]       regDst,
  output logic             aluSrc,
  output logic [1:0]       memToR,
  output logic [2:0]       aluOp,
  output logic             extOp,
  output logic [1:0]       npcSel,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state
);
  state_t           r_state, w_next;
  ctrl_t            w_ctrl, w_out;
  cls_t             w_cls;
  logic             w_illegal, w_mem_go, w_retire;
  logic [CNT_W-1:0] r_cnt;
  mc_decode u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_cls    (w_cls),
    .o_illegal(w_illegal)
  );
`ifdef MC_MEM_WAIT_EN
  assign w_mem_go = mem_rdy;
`else
  logic w_unused_mem_rdy;
  assign w_unused_mem_rdy = mem_rdy;
  assign w_mem_go = 1'b1;
`endif
  // Next state, control word and retire strobe from the current state and decoded class
  always_comb begin
    w_next   = S_FETCH;
    w_ctrl   = '0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.ir_wr = 1'b1;
        w_ctrl.pc_wr = 1'b1;
        w_next       = S_DECODE;
      end
      S_DECODE: begin
        w_next = (w_cls.addu | w_cls.subu | w_cls.ori | w_cls.lw | w_cls.sw) ? S_EXEC :
                 w_cls.lui ? S_WB :
                 (w_cls.beq | w_cls.jal | w_cls.jr) ? S_BRJ : S_FETCH;
        w_ctrl.illegal = w_illegal;
        w_retire       = w_cls.nop;
      end
      S_EXEC: begin
        w_ctrl.alu_op  = w_cls.subu ? ALU_SUB : w_cls.ori ? ALU_OR : ALU_ADD;
        w_ctrl.alu_src = w_cls.ori | w_cls.lw | w_cls.sw;
        w_ctrl.ext_op  = w_cls.lw | w_cls.sw;
        w_next         = (w_cls.lw | w_cls.sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        w_ctrl.mem_wr = w_cls.sw;
        w_next        = !w_mem_go ? S_MEM : w_cls.lw ? S_WB : S_FETCH;
        w_retire      = w_mem_go & w_cls.sw;
      end
      S_WB: begin
        w_ctrl.reg_wr   = 1'b1;
        w_ctrl.reg_dst  = (w_cls.addu | w_cls.subu) ? RD_RD : RD_RT;
        w_ctrl.mem_to_r = w_cls.lw ? MR_DM : w_cls.lui ? MR_LUI : MR_ALU;
        w_retire        = 1'b1;
      end
      S_BRJ: begin
        w_ctrl.alu_op   = w_cls.beq ? ALU_SUB : ALU_ADD;
        w_ctrl.pc_wr    = w_cls.beq ? zero : (w_cls.jal | w_cls.jr);
        w_ctrl.npc_sel  = w_cls.beq ? NPC_BR : w_cls.jal ? NPC_JAL : w_cls.jr ? NPC_RS : NPC_PC4;
        w_ctrl.reg_wr   = w_cls.jal;
        w_ctrl.reg_dst  = w_cls.jal ? RD_RA : RD_RT;
        w_ctrl.mem_to_r = w_cls.jal ? MR_PC4 : MR_ALU;
        w_retire        = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end
  // Reset silences every output immediately, without waiting for a clock edge
  assign w_out = reset ? '0 : w_ctrl;
  assign {pcWr, irWr, regWr, memWr, regDst, aluSrc, memToR, aluOp, extOp, npcSel, illegal} = w_out;
  assign instr_cnt = r_cnt;
  assign state     = r_state;
  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end
  // Retired-instruction counter, wraps freely
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven check of mc_ctrl latencies, control words and retire counting
module tb_mc_ctrl;
  logic        clk, reset, zero, mem_rdy;
  logic [5:0]  opcode, funct;
  logic        pcWr, irWr, regWr, memWr, aluSrc, extOp, illegal;
  logic [1:0]  regDst, memToR, npcSel;
  logic [2:0]  aluOp, state;
  logic [31:0] instr_cnt;
  logic [15:0] ctrl;
  int n_chk = 0;
  int n_fail = 0;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .pcWr(pcWr), .irWr(irWr), .regWr(regWr), .memWr(memWr), .regDst(regDst), .aluSrc(aluSrc),
    .memToR(memToR), .aluOp(aluOp), .extOp(extOp), .npcSel(npcSel), .illegal(illegal),
    .instr_cnt(instr_cnt), .state(state)
  );

  assign ctrl = {pcWr, irWr, regWr, memWr, regDst, aluSrc, memToR, aluOp, extOp, npcSel, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    int          lat;
    logic [15:0] c3;
    logic [15:0] last;
    int          memw;
    int          regw;
    int          inc;
    string       name;
  } vec_t;

  vec_t v[13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Entered and left at a falling edge with the FSM in FETCH.
  task automatic run(input vec_t t);
    int cyc = 0, mw = 0, rw = 0;
    logic [15:0] c3 = '0, last = '0;
    logic [31:0] c0;
    opcode = t.op;
    funct  = t.fn;
    zero   = t.z;
    c0     = instr_cnt;
    do begin
      if (cyc == 2) c3 = ctrl;
      last = ctrl;
      mw += int'(memWr);
      rw += int'(regWr);
      cyc++;
      @(negedge clk);
    end while (state != 3'd0 && cyc < 12);
    chk({t.name, " latency"}, cyc, t.lat);
    chk({t.name, " final ctrl"}, {16'h0, last}, {16'h0, t.last});
    if (t.lat >= 3) chk({t.name, " cycle3 ctrl"}, {16'h0, c3}, {16'h0, t.c3});
    chk({t.name, " memWr cycles"}, mw, t.memw);
    chk({t.name, " regWr cycles"}, rw, t.regw);
    chk({t.name, " retire"}, instr_cnt - c0, t.inc);
  endtask

  initial begin
    v[0]  = '{6'h00, 6'h21, 1'b0, 4, 16'b0_0_0_0_00_0_00_000_0_00_0, 16'b0_0_1_0_01_0_00_000_0_00_0, 0, 1, 1, "addu"};
    v[1]  = '{6'h0D, 6'h00, 1'b0, 4, 16'b0_0_0_0_00_1_00_010_0_00_0, 16'b0_0_1_0_00_0_00_000_0_00_0, 0, 1, 1, "ori"};
    v[2]  = '{6'h0F, 6'h00, 1'b0, 3, 16'b0_0_1_0_00_0_10_000_0_00_0, 16'b0_0_1_0_00_0_10_000_0_00_0, 0, 1, 1, "lui"};
    v[3]  = '{6'h23, 6'h00, 1'b0, 5, 16'b0_0_0_0_00_1_00_000_1_00_0, 16'b0_0_1_0_00_0_01_000_0_00_0, 0, 1, 1, "lw"};
    v[4]  = '{6'h2B, 6'h00, 1'b0, 4, 16'b0_0_0_0_00_1_00_000_1_00_0, 16'b0_0_0_1_00_0_00_000_0_00_0, 1, 0, 1, "sw"};
    v[5]  = '{6'h04, 6'h00, 1'b1, 3, 16'b1_0_0_0_00_0_00_001_0_01_0, 16'b1_0_0_0_00_0_00_001_0_01_0, 0, 0, 1, "beq taken"};
    v[6]  = '{6'h04, 6'h00, 1'b0, 3, 16'b0_0_0_0_00_0_00_001_0_01_0, 16'b0_0_0_0_00_0_00_001_0_01_0, 0, 0, 1, "beq not taken"};
    v[7]  = '{6'h03, 6'h00, 1'b0, 3, 16'b1_0_1_0_10_0_11_000_0_10_0, 16'b1_0_1_0_10_0_11_000_0_10_0, 0, 1, 1, "jal"};
    v[8]  = '{6'h00, 6'h08, 1'b0, 3, 16'b1_0_0_0_00_0_00_000_0_11_0, 16'b1_0_0_0_00_0_00_000_0_11_0, 0, 0, 1, "jr"};
    v[9]  = '{6'h3F, 6'h00, 1'b0, 2, 16'h0000, 16'b0_0_0_0_00_0_00_000_0_00_1, 0, 0, 0, "illegal op"};
    v[10] = '{6'h00, 6'h00, 1'b0, 2, 16'h0000, 16'h0000, 0, 0, 1, "nop"};
    v[11] = '{6'h00, 6'h23, 1'b0, 4, 16'b0_0_0_0_00_0_00_001_0_00_0, 16'b0_0_1_0_01_0_00_000_0_00_0, 0, 1, 1, "subu"};
    v[12] = '{6'h00, 6'h01, 1'b0, 2, 16'h0000, 16'b0_0_0_0_00_0_00_000_0_00_1, 0, 0, 0, "illegal funct"};

    reset = 1'b1;
    opcode = '0;
    funct = '0;
    zero = 1'b0;
`ifdef MC_MEM_WAIT_EN
    mem_rdy = 1'b1;
`else
    mem_rdy = 1'b0;
`endif
    #12;
    chk("reset state", {29'h0, state}, 32'd0);
    chk("reset ctrl", {16'h0, ctrl}, 32'h0);
    chk("reset count", instr_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fetch irWr", {31'h0, irWr}, 32'd1);
    chk("fetch pcWr", {31'h0, pcWr}, 32'd1);

    foreach (v[i]) run(v[i]);
    chk("total count", instr_cnt, 32'd11);

`ifdef MC_MEM_WAIT_EN
    begin
      int mc = 0, mw = 0;
      logic [31:0] cb = '0;
      opcode = 6'h2B;
      funct = '0;
      mem_rdy = 1'b0;
      for (int k = 0; k < 30; k++) begin
        if (state == 3'd3) begin
          mc++;
          mw += int'(memWr);
          if (mc == 4) begin
            mem_rdy = 1'b1;
            cb = instr_cnt;
          end
        end
        @(negedge clk);
        if (state == 3'd0) break;
      end
      chk("wait MEM cycles", mc, 4);
      chk("wait memWr cycles", mw, 4);
      chk("wait retire", instr_cnt, cb + 32'd1);
    end
`endif

    opcode = 6'h00;
    funct  = 6'h21;
    @(negedge clk);
    @(negedge clk);
    chk("addu in EXEC", {29'h0, state}, 32'd2);
    #1 reset = 1'b1;
    #1;
    chk("async reset state", {29'h0, state}, 32'd0);
    chk("async reset ctrl", {16'h0, ctrl}, 32'h0);
    @(posedge clk);
    #1;
    chk("reset no regWr", {31'h0, regWr}, 32'd0);
    chk("reset clears count", instr_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("release state", {29'h0, state}, 32'd0);
    chk("release irWr", {31'h0, irWr}, 32'd1);
    chk("release count", instr_cnt, 32'd0);
    @(posedge clk);
    #1;
    chk("post-release decode", {29'h0, state}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences one instruction over 2–5 clock cycles.
- Drives the register-destination, ALU-source and writeback-source selects, the next-PC select and all write strobes.
- Counts retired instructions.
- Sits beside the datapath: takes opcode/funct from the instruction register and the ALU zero flag, and returns control signals.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], stable from the cycle after FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU equal flag
- mem_rdy  in  1  data-memory ready (used only with MC_MEM_WAIT_EN)
- pcWr  out  1  PC write enable
- irWr  out  1  IR (and instruction-PC) write enable
- regWr  out  1  GRF write enable
- memWr  out  1  DM write enable
- regDst  out  2  00 rt, 01 rd, 10 $31
- aluSrc  out  1  0 RD2, 1 extended immediate
- memToR  out  2  00 ALU result, 01 DM read data, 10 imm<<16, 11 instrPC+4
- aluOp  out  3  000 add, 001 sub, 010 or
- extOp  out  1  0 zero-extend, 1 sign-extend
- npcSel  out  2  00 PC+4, 01 branch target, 10 jal target, 11 rs
- illegal  out  1  one-cycle pulse for an unknown instruction
- instr_cnt  out  CNT_W  retired-instruction count
- state  out  3  current FSM state, for debug

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = FETCH; instr_cnt = 0.
  - All strobes (pcWr, irWr, regWr, memWr, illegal) are forced to 0.
  - All selects are 0.
- Reset mid-instruction aborts the instruction with no further writes; the first cycle after deassertion is FETCH.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRJ=5. Codes 6 and 7 go to FETCH.
- Outputs are combinational from state plus opcode/funct. Select values are don't-care unless listed, and are driven 0.
- FETCH: irWr=1, pcWr=1, npcSel=00. Next state DECODE.
- DECODE: classify the instruction.
  - addu/subu/ori/lw/sw → EXEC.
  - lui → WB.
  - beq/jal/jr → BRJ.
  - nop (word all zero) → FETCH.
  - Unknown → FETCH with illegal=1.
- EXEC:
  - addu: aluOp=000, aluSrc=0.
  - subu: aluOp=001, aluSrc=0.
  - ori: aluOp=010, aluSrc=1, extOp=0.
  - lw/sw: aluOp=000, aluSrc=1, extOp=1.
  - Next state MEM for lw/sw, else WB.
- MEM:
  - sw: memWr=1, then → FETCH.
  - lw: → WB.
- WB: regWr=1.
  - R-type: regDst=01, memToR=00.
  - ori: regDst=00, memToR=00.
  - lw: regDst=00, memToR=01.
  - lui: regDst=00, memToR=10.
  - Next state FETCH.
- BRJ:
  - beq: aluOp=001, aluSrc=0, pcWr=zero, npcSel=01.
  - jal: pcWr=1, npcSel=10, regWr=1, regDst=10, memToR=11.
  - jr: pcWr=1, npcSel=11.
  - Next state FETCH.
- Latency per instruction:
  - R-type and ori: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, jal, jr, lui: 3 cycles.
  - nop and illegal: 2 cycles.
- instr_cnt increments by 1 on the final cycle of each instruction:
  - the state preceding FETCH, including DECODE for nop;
  - illegal instructions are not counted.
  - The counter wraps modulo 2^CNT_W with no saturation.
- regWr and memWr are never both 1 in the same cycle. At most one of pcWr/irWr is set outside FETCH.

Optional Feature:
- MC_MEM_WAIT_EN defined:
  - MEM holds while mem_rdy=0.
  - memWr stays asserted for sw throughout the wait.
  - The transition to WB or FETCH happens on the first cycle with mem_rdy=1.
  - The sw retire count occurs in that cycle.
- MC_MEM_WAIT_EN undefined:
  - mem_rdy is ignored.
  - MEM lasts exactly 1 cycle.

Decomposition:
- mc_pkg holds:
  - state encodings;
  - opcode/funct constants (R=000000, ori=001101, lw=100011, sw=101011, beq=000100, lui=001111, jal=000011; addu=100001, subu=100011, jr=001000);
  - select encodings for regDst, memToR, aluOp and npcSel.
- Sub-module mc_decode: combinational opcode/funct → one-hot instruction class plus illegal.

Test Plan:
- Reset asserted mid-EXEC of addu → all strobes drop asynchronously, no regWr. After release: state=0, irWr=1, instr_cnt=0.
- Sequence addu, ori, lui → 4+4+3 cycles. WB cycles show regDst=01/00/00 and memToR=00/00/10. instr_cnt=3.
- lw followed by sw → 5 cycles then 4 cycles. memWr=1 only in sw's MEM cycle. lw WB has memToR=01. instr_cnt=2.
- beq with zero=1, then beq with zero=0 → BRJ pcWr=1 with npcSel=01, then BRJ pcWr=0. Both take 3 cycles and both are counted.
- jal, then jr, then opcode 111111 → jal BRJ: regWr=1, regDst=10, memToR=11, npcSel=10. jr BRJ: npcSel=11. Unknown opcode: illegal pulses in DECODE, 2 cycles, count unchanged.
- With MC_MEM_WAIT_EN, sw with mem_rdy low for 3 cycles → MEM lasts 4 cycles with memWr held at 1. instr_cnt increments on the mem_rdy=1 cycle.
